// File: rtl/elastic_pr_pkg.sv
// Shared constants, types and a parameter-legality helper for the elastic
// pipeline register.
package elastic_pr_pkg;

  localparam int PR_DEFAULT_DEPTH = 2;
  localparam int PR_DEFAULT_WIDTH = 8;

  typedef logic [$clog2(PR_DEFAULT_DEPTH+1)-1:0] pr_count_t;

  function automatic bit pr_params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/elastic_pr_ctrl.sv
// Pointer/count bookkeeping for the elastic register: qualifies push and pop,
// applies flush and derives the registered-only ready/valid flags.
module elastic_pr_ctrl
  import elastic_pr_pkg::*;
#(
  parameter int DEPTH = PR_DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH+1),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          flush,
  input  logic          i_valid,
  input  logic          o_ready,
  output logic          i_ready,
  output logic          o_valid,
  output logic          push,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  logic pop;

  // Both flags come from count alone, so ready never depends on o_ready.
  assign i_ready = (count != CW'(DEPTH));
  assign o_valid = (count != '0);

  assign push = i_valid & i_ready & ~flush;
  assign pop  = o_valid & o_ready & ~flush;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/elastic_pr.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on
// both sides and a single-cycle flush. Storage and head mux live here.
module elastic_pr
  import elastic_pr_pkg::*;
#(
  parameter int WIDTH = PR_DEFAULT_WIDTH,
  parameter int DEPTH = PR_DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  if (!pr_params_ok(WIDTH, DEPTH)) begin : g_param_check
    $error("elastic_pr: WIDTH must be >= 1 and DEPTH a power of two >= 2");
  end

  logic             push;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  elastic_pr_ctrl #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_ctrl (
    .clk     (clk),
    .n_rst   (n_rst),
    .flush   (flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .push    (push),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .count   (count)
  );

  // Flush leaves contents stale; they are hidden because o_valid drops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  assign o_data = mem[rd_ptr];

endmodule

// File: tb/tb_elastic_pr.sv
// Directed bench for elastic_pr: a DEPTH=2 instance for streaming and a
// DEPTH=4 instance for back-pressure, flush, wrap-around and async reset.
module tb_elastic_pr;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic       fl2, iv2, ir2, ov2, or2;
  logic [7:0] id2, od2;
  logic [1:0] cnt2;

  // DEPTH=4 instance
  logic       fl4, iv4, ir4, ov4, or4;
  logic [7:0] id4, od4;
  logic [2:0] cnt4;

  elastic_pr #(.WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .flush(fl2), .i_valid(iv2), .i_data(id2),
    .i_ready(ir2), .o_valid(ov2), .o_data(od2), .o_ready(or2), .count(cnt2)
  );

  elastic_pr #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .flush(fl4), .i_valid(iv4), .i_data(id4),
    .i_ready(ir4), .o_valid(ov4), .o_data(od4), .o_ready(or4), .count(cnt4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs describe the state seen before this row's inputs are clocked.
  typedef struct packed {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    logic [2:0] cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [7:0] exp_q [$];

  initial begin
    // back-pressure with o_ready low, then drain
    vecs[0]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA0, 1'b1, 3'd1};
    vecs[2]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 1'b1, 3'd2};
    vecs[3]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA0, 1'b1, 3'd3};
    vecs[4]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4};
    vecs[5]  = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 8'hA0, 1'b0, 3'd4};
    vecs[6]  = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 8'hA1, 1'b1, 3'd3};
    vecs[7]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA2, 1'b1, 3'd3};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b1, 3'd3};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 3'd2};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 3'd1};
    // refill three entries across the pointer wrap, then flush with a push
    vecs[11] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0};
    vecs[12] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 3'd1};
    vecs[13] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b1, 3'd2};
    vecs[14] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 8'h11, 1'b1, 3'd3};
    vecs[15] = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h66, 1'b1, 3'd1};
    // empty with push and o_ready together: no bypass
    vecs[17] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1, 3'd1};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0};

    n_rst = 1'b0;
    fl2 = 0; iv2 = 0; id2 = '0; or2 = 0;
    fl4 = 0; iv4 = 0; id4 = '0; or4 = 0;

    // reset then idle
    #3;
    for (int r = 0; r < 2; r++) begin
      check("rst2_ov", ov2, 0);  check("rst2_ir", ir2, 1);
      check("rst2_cnt", cnt2, 0); check("rst2_od", od2, 0);
      check("rst4_ov", ov4, 0);  check("rst4_ir", ir4, 1);
      check("rst4_cnt", cnt4, 0); check("rst4_od", od4, 0);
      if (r == 0) begin
        #9 n_rst = 1'b1;
        repeat (3) tick();
      end
    end

    // streaming on DEPTH=2
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) begin
        check("stream_ov0", ov2, 0);
      end else begin
        check("stream_ov", ov2, 1);
        check("stream_od", od2, k);
        check("stream_cnt", cnt2, 1);
      end
      check("stream_ir", ir2, 1);
      iv2 = (k < 16); id2 = 8'(k + 1); or2 = 1'b1;
      tick();
    end
    iv2 = 0; or2 = 0;
    check("stream_end_cnt", cnt2, 0);
    check("stream_end_ov", ov2, 0);

    // table-driven vectors on DEPTH=4
    for (int i = 0; i < NV; i++) begin
      check($sformatf("v%0d_ov", i), ov4, vecs[i].ov);
      check($sformatf("v%0d_ir", i), ir4, vecs[i].ir);
      check($sformatf("v%0d_cnt", i), cnt4, vecs[i].cnt);
      if (vecs[i].ov) check($sformatf("v%0d_od", i), od4, vecs[i].od);
      fl4 = vecs[i].fl; iv4 = vecs[i].iv; id4 = vecs[i].id; or4 = vecs[i].ordy;
      tick();
    end
    fl4 = 0; iv4 = 0; or4 = 0;

    // wrap-around with random stalls against a FIFO reference
    for (int c = 0; c < 10; c++) begin
      logic do_push, do_pop;
      check("wrap_cnt", cnt4, exp_q.size());
      if (exp_q.size() > 0) check("wrap_od", od4, exp_q[0]);
      iv4 = 1'b1; id4 = 8'($urandom_range(0, 255)); or4 = 1'($urandom_range(0, 1));
      do_push = (exp_q.size() < 4);
      do_pop  = (exp_q.size() > 0) && or4;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(id4);
      tick();
    end
    iv4 = 1'b0; or4 = 1'b1;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      check("drain_cnt", cnt4, exp_q.size());
      check("drain_od", od4, exp_q[0]);
      void'(exp_q.pop_front());
      tick();
    end
    or4 = 1'b0;
    check("drain_end_cnt", cnt4, 0);

    // async reset mid-stream with three entries held
    iv4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      id4 = 8'hC1 + 8'(c);
      tick();
    end
    iv4 = 1'b0;
    check("pre_arst_cnt", cnt4, 3);
    #2 n_rst = 1'b0;
    #1;
    check("arst_ov", ov4, 0);
    check("arst_cnt", cnt4, 0);
    check("arst_ir", ir4, 1);
    #1 n_rst = 1'b1;
    tick();
    iv4 = 1'b1; id4 = 8'h88;
    tick();
    iv4 = 1'b0; or4 = 1'b1;
    check("post_arst_ov", ov4, 1);
    check("post_arst_od", od4, 8'h88);
    check("post_arst_cnt", cnt4, 1);
    tick();
    or4 = 1'b0;
    check("post_arst_empty", ov4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
